// File: rtl/mem_sink.sv
// mem_sink: downstream sink for the two-master merge path.
// Grants the path's bus request, captures granted bytes into a sequential
// store of DEPTH entries, offers a registered readback port and flags
// protocol violations (data offered without grant or while full).
// Optional feature macro: GNT_DELAY_EN -- inserts a WAIT state so the grant
// lags the request by GNT_DELAY cycles (slow-bus back-pressure).
module mem_sink #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned GNT_DELAY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic                     valid_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     clear_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     err_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("mem_sink: DEPTH must be a power of two and at least 2");
  end
  if (GNT_DELAY < 1) begin : g_delay_check
    $error("mem_sink: GNT_DELAY must be at least 1");
  end

`ifdef GNT_DELAY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GRANT, ST_FULL} state_t;

  localparam int unsigned    CW      = $clog2(GNT_DELAY + 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  CNT_LD  = CW'(GNT_DELAY);

  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_nxt;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_FULL} state_t;
`endif

  state_t            state;
  state_t            state_nxt;
  logic              wr_en;
  logic              viol;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic              err;
  logic [DATA_W-1:0] store [DEPTH];

  // A byte is accepted only under grant outside FULL; clear wins over both
  // the write and the violation flag.
  assign wr_en = valid_i && gnt_o && (state != ST_FULL) && !clear_i;
  assign viol  = valid_i && (!gnt_o || (state == ST_FULL)) && !clear_i;

  assign count_o = count;
  assign full_o  = (count == FULL_CNT);
  assign err_o   = err;

  // Next-state logic for the grant FSM.
  always_comb begin
    state_nxt = state;
`ifdef GNT_DELAY_EN
    wait_cnt_nxt = wait_cnt;
`endif
    if (clear_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i) begin
`ifdef GNT_DELAY_EN
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = CNT_LD;
`else
            state_nxt    = ST_GRANT;
`endif
          end
        end
`ifdef GNT_DELAY_EN
        ST_WAIT: begin
          wait_cnt_nxt = wait_cnt - CNT_ONE;
          if (!req_i) begin
            state_nxt = ST_IDLE;
          end else if (wait_cnt == CNT_ONE) begin
            state_nxt = ST_GRANT;
          end
        end
`endif
        ST_GRANT: begin
          // Filling the store takes priority over a simultaneous req drop.
          if (wr_en && (count == LAST_CNT)) begin
            state_nxt = ST_FULL;
          end else if (!req_i) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_FULL: begin
          state_nxt = ST_FULL;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register; grant is registered from the next state so it rises and
  // falls on the same edge as the state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt_o <= 1'b0;
`ifdef GNT_DELAY_EN
      wait_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      gnt_o <= (state_nxt == ST_GRANT);
`ifdef GNT_DELAY_EN
      wait_cnt <= wait_cnt_nxt;
`endif
    end
  end

  // Write pointer and byte count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end
  end

  // Sticky protocol-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (clear_i) begin
      err <= 1'b0;
    end else if (viol) begin
      err <= 1'b1;
    end
  end

  // Store write port; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      store[wr_ptr] <= data_i;
    end
  end

  // Registered readback; a same-cycle write to the same address returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= store[rd_addr_i];
    end
  end

endmodule
